// File: rtl/conbus_nxm.sv
// Wishbone shared-bus interconnect for NM masters and NS slaves.
// Provides round-robin grant, base/mask decode, an unmapped-address responder and a stalled-slave watchdog.
module conbus_nxm #(
  parameter int               NM         = 5,
  parameter int               NS         = 7,
  parameter logic [NS*32-1:0] SLAVE_BASE = {NS{32'h0000_0000}},
  parameter logic [NS*32-1:0] SLAVE_MASK = {NS{32'hE000_0000}},
  parameter int               TIMEOUT    = 256,
  parameter logic [31:0]      ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [NM*32-1:0] m_dat_i,
  output logic [NM*32-1:0] m_dat_o,
  input  logic [NM*32-1:0] m_adr_i,
  input  logic [NM*3-1:0]  m_cti_i,
  input  logic [NM*4-1:0]  m_sel_i,
  input  logic [NM-1:0]    m_we_i,
  input  logic [NM-1:0]    m_cyc_i,
  input  logic [NM-1:0]    m_stb_i,
  output logic [NM-1:0]    m_ack_o,
  input  logic [NS*32-1:0] s_dat_i,
  output logic [NS*32-1:0] s_dat_o,
  output logic [NS*32-1:0] s_adr_o,
  output logic [NS*3-1:0]  s_cti_o,
  output logic [NS*4-1:0]  s_sel_o,
  output logic [NS-1:0]    s_we_o,
  output logic [NS-1:0]    s_stb_o,
  output logic [NS-1:0]    s_cyc_o,
  input  logic [NS-1:0]    s_ack_i,
  output logic [3:0]       gnt_o,
  output logic             timeout_o,
  output logic             unmapped_o,
  output logic [31:0]      err_adr_o,
  output logic [3:0]       err_master_o
);

  localparam int GB = (NM > 1) ? $clog2(NM) : 1;
  localparam int SB = (NS > 1) ? $clog2(NS) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [31:0]   m_dat_a_s [NM];
  logic [31:0]   m_adr_a_s [NM];
  logic [2:0]    m_cti_a_s [NM];
  logic [3:0]    m_sel_a_s [NM];
  logic [31:0]   s_dat_a_s [NS];

  logic [GB-1:0] gnt_r;
  logic [GB-1:0] gnt_nxt_s;
  logic [GB-1:0] cand_s;
  logic          pick_s;
  logic          found_s;
  logic [NS-1:0] match_s;
  logic [NS-1:0] sel_s;
  logic [SB-1:0] sel_idx_s;
  logic          hit_s;
  logic          g_cyc_s;
  logic          g_stb_s;
  logic [31:0]   g_adr_s;
  logic          ack_sel_s;
  logic          stall_s;
  logic          unmap_s;
  logic          expire_s;
  logic          int_ack_r;
  logic          timeout_r;
  logic          unmapped_r;
  logic [31:0]   err_adr_r;
  logic [3:0]    err_master_r;
  logic [WW-1:0] wdog_r;

  // Unpack the flat master/slave buses into per-port arrays
  always_comb begin
    for (int j = 0; j < NM; j++) begin
      m_dat_a_s[j] = m_dat_i[32*j +: 32];
      m_adr_a_s[j] = m_adr_i[32*j +: 32];
      m_cti_a_s[j] = m_cti_i[3*j +: 3];
      m_sel_a_s[j] = m_sel_i[4*j +: 4];
    end
    for (int k = 0; k < NS; k++) begin
      s_dat_a_s[k] = s_dat_i[32*k +: 32];
    end
  end

  assign g_cyc_s = m_cyc_i[gnt_r];
  assign g_stb_s = m_stb_i[gnt_r];
  assign g_adr_s = m_adr_a_s[gnt_r];

  // Address decode of the granted master; the lowest matching slave wins
  always_comb begin
    match_s   = '0;
    sel_s     = '0;
    sel_idx_s = '0;
    hit_s     = 1'b0;
    for (int k = 0; k < NS; k++) begin
      match_s[k] = ((g_adr_s & SLAVE_MASK[32*k +: 32]) == (SLAVE_BASE[32*k +: 32] & SLAVE_MASK[32*k +: 32]));
      sel_s[k]   = match_s[k] & ~hit_s;
      sel_idx_s  = sel_s[k] ? SB'(k) : sel_idx_s;
      hit_s      = hit_s | match_s[k];
    end
  end

  // Round-robin search starting after the current grant, current grant last
  always_comb begin
    gnt_nxt_s = gnt_r;
    found_s   = 1'b0;
    cand_s    = gnt_r;
    pick_s    = 1'b0;
    for (int i = 1; i <= NM; i++) begin
      cand_s    = GB'((int'(gnt_r) + i) % NM);
      pick_s    = ~g_cyc_s & m_cyc_i[cand_s] & ~found_s;
      gnt_nxt_s = pick_s ? cand_s : gnt_nxt_s;
      found_s   = found_s | pick_s;
    end
  end

  assign ack_sel_s = |(s_ack_i & sel_s);
  assign stall_s   = g_cyc_s & g_stb_s & hit_s & ~ack_sel_s;
  assign unmap_s   = g_cyc_s & g_stb_s & ~hit_s & ~int_ack_r;
  // A slave ack in the expiry cycle suppresses the forced ack via stall_s
  assign expire_s  = (TIMEOUT > 0) & stall_s & ~int_ack_r & (wdog_r == WW'(TIMEOUT - 1));

  // Return path: ack only to the granted master, data broadcast to all
  always_comb begin
    m_ack_o        = '0;
    m_ack_o[gnt_r] = ack_sel_s | int_ack_r;
    m_dat_o        = {NM{int_ack_r ? ERR_DATA : s_dat_a_s[sel_idx_s]}};
  end

  assign s_dat_o = {NS{m_dat_a_s[gnt_r]}};
  assign s_adr_o = {NS{g_adr_s}};
  assign s_cti_o = {NS{m_cti_a_s[gnt_r]}};
  assign s_sel_o = {NS{m_sel_a_s[gnt_r]}};
  assign s_we_o  = {NS{m_we_i[gnt_r]}};
  assign s_stb_o = {NS{g_stb_s}};
  // timeout_r doubles as the abort that drops cyc to the stalled slave
  assign s_cyc_o = {NS{g_cyc_s & ~timeout_r}} & sel_s;

  // Grant register, internal ack pulse and error capture
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      gnt_r        <= '0;
      int_ack_r    <= 1'b0;
      timeout_r    <= 1'b0;
      unmapped_r   <= 1'b0;
      err_adr_r    <= 32'h0000_0000;
      err_master_r <= 4'h0;
    end else begin
      gnt_r      <= gnt_nxt_s;
      int_ack_r  <= unmap_s | expire_s;
      timeout_r  <= expire_s;
      unmapped_r <= unmap_s;
      if (unmap_s | expire_s) begin
        err_adr_r    <= g_adr_s;
        err_master_r <= 4'(gnt_r);
      end else begin
        err_adr_r    <= err_adr_r;
        err_master_r <= err_master_r;
      end
    end
  end

  // Watchdog counts consecutive stalled strobe cycles of one tenure
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wdog_r <= '0;
    end else if ((TIMEOUT == 0) || !stall_s || int_ack_r || expire_s || (gnt_nxt_s != gnt_r)) begin
      wdog_r <= '0;
    end else begin
      wdog_r <= wdog_r + WW'(1);
    end
  end

  assign gnt_o        = 4'(gnt_r);
  assign timeout_o    = timeout_r;
  assign unmapped_o   = unmapped_r;
  assign err_adr_o    = err_adr_r;
  assign err_master_o = err_master_r;

endmodule
